fp_sign_unit: RTL and testbench
===============================

# fp_sign_unit

Parametrised, pipelined sign-manipulation and classification unit for the FP execution path. It supports FSGNJ/FSGNJN/FSGNJX and FCLASS for single precision and, when FLEN=64, double precision. Single-precision operands are NaN-box checked and single-precision results are NaN-boxed. The unit has one register stage with a valid/ready handshake and an opaque tag carried through for writeback.

## Interface

Parameters:
- FLEN, 64 — FP register width; legal values are 32 and 64.
- TAG_W, 5 — width of the pass-through tag (destination register index).

Ports:
- in_clk  input  1 — clock; all state updates on the rising edge.
- in_rst  input  1 — reset, synchronous and active-high.
- in_valid  input  1 — upstream offers an operation this cycle.
- out_ready  output  1 — unit can accept an operation this cycle.
- in_numA  input  FLEN — operand A (magnitude source; FCLASS source).
- in_numB  input  FLEN — operand B (sign source).
- in_ctrl_jnx  input  2 — 00 SGNJ, 01 SGNJN, 10 SGNJX, 11 FCLASS.
- in_dp  input  1 — 1 = double precision. Ignored (treated as 0) when FLEN=32.
- in_tag  input  TAG_W — carried to out_tag unchanged.
- out_valid  output  1 — result register holds a valid result.
- in_ready  input  1 — downstream accepts the result this cycle.
- out_data  output  FLEN — result.
- out_tag  output  TAG_W — tag of the result.

## Operation

- **Transfer rules.** An input transfer occurs when in_valid && out_ready at a rising edge. An output transfer occurs when out_valid && in_ready at a rising edge.
- **Single-precision unboxing** (FLEN=64, in_dp=0): an operand is properly boxed iff bits [63:32] are all ones. An improperly boxed operand is replaced by the canonical NaN 0x7FC00000 before any operation. When FLEN=32, no box check is performed.
- **Width selection.** The effective operand width W is 64 if in_dp=1 (FLEN=64), else 32. Sign bit is bit W-1.
- **SGNJ:** result = {B[W-1], A[W-2:0]}.
- **SGNJN:** result = {~B[W-1], A[W-2:0]}.
- **SGNJX:** result = {A[W-1]^B[W-1], A[W-2:0]}.
- **Result boxing.** A single-precision SGNJ* result with FLEN=64 is NaN-boxed: out_data[63:32] = all ones.
- **FCLASS** (in_numB ignored): a 10-bit one-hot mask of unboxed A, zero-extended to FLEN.
  - bit 0: −inf
  - bit 1: −normal
  - bit 2: −subnormal
  - bit 3: −0
  - bit 4: +0
  - bit 5: +subnormal
  - bit 6: +normal
  - bit 7: +inf
  - bit 8: sNaN (exponent all ones, mantissa MSB 0, mantissa ≠ 0)
  - bit 9: qNaN (exponent all ones, mantissa MSB 1)
  - An improperly boxed single-precision A classifies as qNaN (0x200).
- **Exceptions.** No exception flags are raised by any operation, including on NaN inputs.
- **Tag.** out_tag is captured with out_data and travels with it.

## Timing

- **Latency:** 1 cycle. An operation accepted at edge N appears with out_valid=1 after edge N.
- **Ready:** out_ready = !out_valid || in_ready (combinational from in_ready). This sustains 1 operation per cycle when downstream is always ready.
- **Simultaneous output and input transfer** in one cycle: the register is reloaded with the new operation and out_valid stays 1.
- **Output transfer only:** out_valid clears to 0 at that edge.
- **Stall** (out_valid=1, in_ready=0): out_data and out_tag are held stable, out_ready=0, and upstream inputs are not sampled.
- **Reset values:** out_valid=0, out_data=0, out_tag=0. Reset has priority over any transfer in the same cycle. A result pending at reset is discarded.
- **Idle cycles:** in_valid=0 with the register empty leaves out_data and out_tag at their previous values; only out_valid is meaningful.

## Test plan

1. **Boxed single-precision SGNJ.** FLEN=64, in_dp=0, SGNJ, A=0xFFFFFFFF_3F800000, B=0xFFFFFFFF_C0000000, tag=3 -> next cycle out_valid=1, out_data=0xFFFFFFFF_BF800000, out_tag=3.
2. **Bad box on A.** FLEN=64, in_dp=0, SGNJN, A=0x00000000_3F800000, B=0xFFFFFFFF_40000000 -> out_data=0xFFFFFFFF_FFC00000.
3. **Double-precision SGNJX.** in_dp=1, A=0xC000000000000000, B=0x8000000000000000 -> out_data=0x4000000000000000.
4. **FCLASS.** in_dp=1, A=0x7FF0000000000001 -> 0x100. Then in_dp=0, A=0xFFFFFFFF_80000000 -> 0x008. Then in_dp=0, A=0x00000000_00000000 -> 0x200.
5. **Backpressure.** Issue tags 1, 2, 3 back-to-back with in_ready=0 for 3 cycles after the first result. Required:
   - tag 1 is held stable and out_ready=0 during the stall;
   - tag 2 is accepted on the cycle in_ready rises;
   - outputs appear in order 1, 2, 3 with no loss or duplication;
   - at 100% in_ready, throughput is 1 per cycle.
6. **Reset mid-stream.** Assert in_rst for 1 cycle while out_valid=1 and in_valid=1 -> after the edge out_valid=0, out_data=0, out_tag=0, and the offered operation is not captured. Normal operation resumes on the next cycle.

Source files
------------

// File: rtl/fp_sign_unit_if.sv
// Operation/result handshake bundle between the FP issue stage, fp_sign_unit and writeback.
// The master drives operations and in_ready; the slave (the unit) drives out_ready and results.
interface fp_sign_unit_if #(
  parameter int FLEN  = 64,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             out_ready;
  logic [FLEN-1:0]  in_numA;
  logic [FLEN-1:0]  in_numB;
  logic [1:0]       in_ctrl_jnx;
  logic             in_dp;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             in_ready;
  logic [FLEN-1:0]  out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_numA, in_numB, in_ctrl_jnx, in_dp, in_tag, in_ready,
    input  out_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_numA, in_numB, in_ctrl_jnx, in_dp, in_tag, in_ready,
    output out_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/fp_sign_unit.sv
// FSGNJ/FSGNJN/FSGNJX/FCLASS with single-precision NaN-box handling; one register stage.
// Latency 1 cycle; out_ready = !out_valid || in_ready, so a stalled result blocks new input.
module fp_sign_unit #(
  parameter int FLEN  = 64,
  parameter int TAG_W = 5
) (
  input logic           in_clk,
  input logic           in_rst,
  fp_sign_unit_if.slave io
);
  localparam logic [31:0] QNAN_SP = 32'h7FC0_0000;

  logic [63:0]      w_a64, w_b64;
  logic             w_dp;
  logic             w_a_boxed, w_b_boxed;
  logic [63:0]      w_ua, w_ub;
  logic             w_sa, w_sb, w_sr;
  logic             w_exp_ones, w_exp_zero, w_man_zero, w_man_msb;
  logic [9:0]       w_class;
  logic [63:0]      w_sgnj;
  logic [63:0]      w_result;
  logic             w_unused;
  logic             r_valid;
  logic [FLEN-1:0]  r_data;
  logic [TAG_W-1:0] r_tag;

  assign w_a64 = 64'(io.in_numA);
  assign w_b64 = 64'(io.in_numB);
  assign w_dp  = (FLEN == 64) && io.in_dp;

  // Narrow configurations have no box to check; wide ones replace bad boxes with canonical qNaN
  assign w_a_boxed = (FLEN == 32) || (&w_a64[63:32]);
  assign w_b_boxed = (FLEN == 32) || (&w_b64[63:32]);
  assign w_ua = w_dp ? w_a64 : {32'd0, (w_a_boxed ? w_a64[31:0] : QNAN_SP)};
  assign w_ub = w_dp ? w_b64 : {32'd0, (w_b_boxed ? w_b64[31:0] : QNAN_SP)};

  assign w_sa = w_dp ? w_ua[63] : w_ua[31];
  assign w_sb = w_dp ? w_ub[63] : w_ub[31];
  // Only the sign of B ever reaches the result
  assign w_unused = ^{w_ub[62:32], w_ub[30:0]};

  always_comb begin
    w_sr = w_sb;
    case (io.in_ctrl_jnx)
      2'b00:   w_sr = w_sb;
      2'b01:   w_sr = ~w_sb;
      default: w_sr = w_sa ^ w_sb;
    endcase
  end

  assign w_sgnj = w_dp ? {w_sr, w_ua[62:0]}
                       : {{32{FLEN == 64}}, w_sr, w_ua[30:0]};

  assign w_exp_ones = w_dp ? (&w_ua[62:52])  : (&w_ua[30:23]);
  assign w_exp_zero = w_dp ? ~(|w_ua[62:52]) : ~(|w_ua[30:23]);
  assign w_man_zero = w_dp ? ~(|w_ua[51:0])  : ~(|w_ua[22:0]);
  assign w_man_msb  = w_dp ? w_ua[51]        : w_ua[22];

  always_comb begin
    w_class = '0;
    if (w_exp_ones) begin
      if (w_man_zero) begin
        if (w_sa) w_class[0] = 1'b1;
        else      w_class[7] = 1'b1;
      end else if (w_man_msb) begin
        w_class[9] = 1'b1;
      end else begin
        w_class[8] = 1'b1;
      end
    end else if (w_exp_zero) begin
      if (w_man_zero) begin
        if (w_sa) w_class[3] = 1'b1;
        else      w_class[4] = 1'b1;
      end else begin
        if (w_sa) w_class[2] = 1'b1;
        else      w_class[5] = 1'b1;
      end
    end else begin
      if (w_sa) w_class[1] = 1'b1;
      else      w_class[6] = 1'b1;
    end
  end

  assign w_result = (io.in_ctrl_jnx == 2'b11) ? {54'd0, w_class} : w_sgnj;

  assign io.out_ready = !r_valid || io.in_ready;

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_tag   <= '0;
    end else if (io.in_valid && io.out_ready) begin
      r_valid <= 1'b1;
      r_data  <= w_result[FLEN-1:0];
      r_tag   <= io.in_tag;
    end else if (io.in_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign io.out_valid = r_valid;
  assign io.out_data  = r_data;
  assign io.out_tag   = r_tag;
endmodule

// File: tb/tb_fp_sign_unit.sv
// Directed and randomized checks of fp_sign_unit against an arithmetic reference model.
module tb_fp_sign_unit;
  localparam int FLEN  = 64;
  localparam int TAG_W = 5;

  typedef struct {
    logic [63:0]      data;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic in_clk = 1'b0;
  logic in_rst;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  fp_sign_unit_if #(.FLEN(FLEN), .TAG_W(TAG_W)) bus ();
  fp_sign_unit #(.FLEN(FLEN), .TAG_W(TAG_W)) dut (
    .in_clk (in_clk),
    .in_rst (in_rst),
    .io     (bus)
  );

  always #5 in_clk = ~in_clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge in_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic dp,
                       input logic [63:0] a, input logic [63:0] b, input logic [TAG_W-1:0] t);
    bus.in_valid    = v;
    bus.in_ctrl_jnx = op;
    bus.in_dp       = dp;
    bus.in_numA     = a;
    bus.in_numB     = b;
    bus.in_tag      = t;
  endtask

  // Reference: field extraction with shifts/masks at the selected width
  function automatic logic [63:0] ref_op(input logic [1:0] op, input logic dp,
                                         input logic [63:0] a, input logic [63:0] b);
    logic [63:0] ua, ub, smask, mmask, emask, ex, man, r;
    int          mbits, ebits, idx;
    logic        neg, neg_r;
    if (dp) begin
      ua = a; ub = b; mbits = 52; ebits = 11;
    end else begin
      ua = (a[63:32] == 32'hFFFF_FFFF) ? {32'd0, a[31:0]} : 64'h7FC0_0000;
      ub = (b[63:32] == 32'hFFFF_FFFF) ? {32'd0, b[31:0]} : 64'h7FC0_0000;
      mbits = 23; ebits = 8;
    end
    smask = 64'd1 << (mbits + ebits);
    mmask = (64'd1 << mbits) - 64'd1;
    emask = (64'd1 << ebits) - 64'd1;
    neg   = (ua & smask) != 64'd0;
    if (op == 2'd3) begin
      ex  = (ua >> mbits) & emask;
      man = ua & mmask;
      if (ex == emask)
        idx = (man == 64'd0) ? (neg ? 0 : 7) : ((man >= (64'd1 << (mbits - 1))) ? 9 : 8);
      else if (ex == 64'd0)
        idx = (man == 64'd0) ? (neg ? 3 : 4) : (neg ? 2 : 5);
      else
        idx = neg ? 1 : 6;
      r = 64'd1 << idx;
    end else begin
      case (op)
        2'd0:    neg_r = (ub & smask) != 64'd0;
        2'd1:    neg_r = (ub & smask) == 64'd0;
        default: neg_r = ((ua ^ ub) & smask) != 64'd0;
      endcase
      r = (ua & (smask - 64'd1)) | (neg_r ? smask : 64'd0);
      if (!dp) r = r | 64'hFFFF_FFFF_0000_0000;
    end
    return r;
  endfunction

  function automatic logic [63:0] rnd_val(input logic dp);
    logic [63:0] v;
    int          k;
    v = {$urandom, $urandom};
    k = $urandom_range(0, 7);
    if (dp) begin
      if (k == 0) v[62:52] = '1;
      if (k == 1) v[62:52] = '0;
      if (k == 2) begin v[62:52] = '1; v[51:0] = '0; end
      if (k == 3) v[62:0] = '0;
    end else begin
      if (k < 6)  v[63:32] = '1;
      if (k == 0) v[30:23] = '1;
      if (k == 1) v[30:23] = '0;
      if (k == 2) begin v[30:23] = '1; v[22:0] = '0; end
      if (k == 3) v[30:0] = '0;
    end
    return v;
  endfunction

  task automatic single(input string name, input logic [1:0] op, input logic dp,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [TAG_W-1:0] t, input logic [63:0] exp);
    drive(1'b1, op, dp, a, b, t);
    bus.in_ready = 1'b1;
    step();
    drive(1'b0, 2'd0, 1'b0, 64'd0, 64'd0, '0);
    check({name, "_vld"}, 64'(bus.out_valid), 64'd1);
    check({name, "_dat"}, bus.out_data, exp);
    check({name, "_tag"}, 64'(bus.out_tag), 64'(t));
    step();
    check({name, "_drain"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    logic [63:0]      a, b, d1, d2, d3;
    logic             v, dp, rdy_exp;
    logic [1:0]       op;
    logic [TAG_W-1:0] t;
    exp_t             e;

    in_rst = 1'b1;
    bus.in_ready = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 64'd0, 64'd0, '0);
    step();
    step();
    check("rst_vld", 64'(bus.out_valid), 64'd0);
    check("rst_dat", bus.out_data, 64'd0);
    check("rst_tag", 64'(bus.out_tag), 64'd0);
    check("rst_rdy", 64'(bus.out_ready), 64'd1);
    in_rst = 1'b0;

    single("sgnj_sp",   2'd0, 1'b0, 64'hFFFFFFFF_3F800000, 64'hFFFFFFFF_C0000000, 5'd3, 64'hFFFFFFFF_BF800000);
    single("badbox_a",  2'd1, 1'b0, 64'h00000000_3F800000, 64'hFFFFFFFF_40000000, 5'd4, 64'hFFFFFFFF_FFC00000);
    single("sgnjx_dp",  2'd2, 1'b1, 64'hC000000000000000, 64'h8000000000000000, 5'd5, 64'h4000000000000000);
    single("class_snan",2'd3, 1'b1, 64'h7FF0000000000001, 64'h1234, 5'd6, 64'h100);
    single("class_nz",  2'd3, 1'b0, 64'hFFFFFFFF_80000000, 64'h0, 5'd7, 64'h008);
    single("class_box", 2'd3, 1'b0, 64'h00000000_00000000, 64'h0, 5'd8, 64'h200);
    single("class_ninf",2'd3, 1'b0, 64'hFFFFFFFF_FF800000, 64'h0, 5'd9, 64'h001);
    single("class_psub",2'd3, 1'b1, 64'h0000000000000001, 64'h0, 5'd10, 64'h020);
    single("badbox_b",  2'd0, 1'b0, 64'hFFFFFFFF_BF800000, 64'h12345678_00000000, 5'd11, 64'hFFFFFFFF_3F800000);
    single("dp_nobox",  2'd0, 1'b1, 64'h00000000_3F800000, 64'h8000000000000000, 5'd12, 64'h80000000_3F800000);

    // Backpressure: tag 1 stalls three cycles while tag 2 waits at the input
    a = rnd_val(1'b1); b = rnd_val(1'b1); d1 = ref_op(2'd0, 1'b1, a, b);
    bus.in_ready = 1'b0;
    drive(1'b1, 2'd0, 1'b1, a, b, 5'd1);
    step();
    a = rnd_val(1'b0); b = rnd_val(1'b0); d2 = ref_op(2'd2, 1'b0, a, b);
    drive(1'b1, 2'd2, 1'b0, a, b, 5'd2);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_stall_rdy", 64'(bus.out_ready), 64'd0);
      check("bp_stall_vld", 64'(bus.out_valid), 64'd1);
      check("bp_stall_tag", 64'(bus.out_tag), 64'd1);
      check("bp_stall_dat", bus.out_data, d1);
      step();
    end
    bus.in_ready = 1'b1;
    #1;
    check("bp_rise_rdy", 64'(bus.out_ready), 64'd1);
    check("bp_rise_tag", 64'(bus.out_tag), 64'd1);
    step();
    check("bp_tag2", 64'(bus.out_tag), 64'd2);
    check("bp_dat2", bus.out_data, d2);
    a = rnd_val(1'b1); b = rnd_val(1'b1); d3 = ref_op(2'd3, 1'b1, a, b);
    drive(1'b1, 2'd3, 1'b1, a, b, 5'd3);
    step();
    check("bp_tag3", 64'(bus.out_tag), 64'd3);
    check("bp_dat3", bus.out_data, d3);
    drive(1'b0, 2'd0, 1'b0, 64'd0, 64'd0, '0);
    step();
    check("bp_empty", 64'(bus.out_valid), 64'd0);

    // Full-rate streaming: one result per cycle with in_ready held high
    for (int i = 0; i < 20; i++) begin
      op = 2'($urandom_range(0, 3)); dp = 1'($urandom_range(0, 1));
      a = rnd_val(dp); b = rnd_val(dp); t = TAG_W'(i);
      drive(1'b1, op, dp, a, b, t);
      #1;
      check("tput_rdy", 64'(bus.out_ready), 64'd1);
      step();
      check("tput_vld", 64'(bus.out_valid), 64'd1);
      check("tput_dat", bus.out_data, ref_op(op, dp, a, b));
      check("tput_tag", 64'(bus.out_tag), 64'(t));
    end
    drive(1'b0, 2'd0, 1'b0, 64'd0, 64'd0, '0);
    step();
    check("tput_empty", 64'(bus.out_valid), 64'd0);

    // Random valid/ready traffic against a one-deep scoreboard
    for (int c = 0; c < 300; c++) begin
      v  = ($urandom_range(0, 3) != 0);
      op = 2'($urandom_range(0, 3)); dp = 1'($urandom_range(0, 1));
      a  = rnd_val(dp); b = rnd_val(dp); t = TAG_W'($urandom);
      drive(v, op, dp, a, b, t);
      bus.in_ready = ($urandom_range(0, 2) != 0);
      #1;
      rdy_exp = (q.size() == 0) || bus.in_ready;
      check("rnd_rdy", 64'(bus.out_ready), 64'(rdy_exp));
      check("rnd_vld", 64'(bus.out_valid), 64'(q.size() != 0));
      if (q.size() != 0) begin
        check("rnd_dat", bus.out_data, q[0].data);
        check("rnd_tag", 64'(bus.out_tag), 64'(q[0].tag));
        if (bus.in_ready) void'(q.pop_front());
      end
      if (v && rdy_exp) begin
        e.data = ref_op(op, dp, a, b);
        e.tag  = t;
        q.push_back(e);
      end
      step();
    end
    drive(1'b0, 2'd0, 1'b0, 64'd0, 64'd0, '0);
    bus.in_ready = 1'b1;
    step();
    q.delete();

    // Reset while a result is pending and a new operation is offered
    bus.in_ready = 1'b0;
    drive(1'b1, 2'd0, 1'b1, 64'h3FF0000000000000, 64'h8000000000000000, 5'd9);
    step();
    check("rst_pre_vld", 64'(bus.out_valid), 64'd1);
    drive(1'b1, 2'd1, 1'b1, 64'h4000000000000000, 64'h0, 5'd10);
    bus.in_ready = 1'b1;
    in_rst = 1'b1;
    step();
    in_rst = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 64'd0, 64'd0, '0);
    check("rst_mid_vld", 64'(bus.out_valid), 64'd0);
    check("rst_mid_dat", bus.out_data, 64'd0);
    check("rst_mid_tag", 64'(bus.out_tag), 64'd0);
    step();
    check("rst_nocap", 64'(bus.out_valid), 64'd0);
    single("resume", 2'd1, 1'b1, 64'h4000000000000000, 64'h0, 5'd13, 64'hC000000000000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
